shift_delay_line: RTL and testbench
===================================

Name: shift_delay_line

Overview:
- Parametrised multi-stage register delay line. Successor to the fixed 8x16 stage shifter.
- Adds per-stage valid tracking, shift enable, flush, a runtime tap readout and an occupancy counter.
- Used as a programmable pipeline-alignment and delay element between datapath stages.

Parameters:
- WIDTH, 16, data width per stage in bits (>=1).
- DEPTH, 8, number of stages (>=2).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).
- SEL_W, $clog2(DEPTH), tap select width (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- shift_en  in  1  advances the line one stage on this edge.
- flush  in  1  clears all stages on this edge.
- in_valid  in  1  qualifier for in_data, sampled with shift_en.
- in_data  in  WIDTH  data into stage 0.
- tap_sel  in  SEL_W  stage index for tap readout.
- tap_data  out  WIDTH  data of stage tap_sel (combinational mux).
- tap_valid  out  1  valid bit of stage tap_sel.
- tap_err  out  1  tap_sel >= DEPTH.
- out_data  out  WIDTH  last stage, S[DEPTH-1].
- out_valid  out  1  valid bit of the last stage, V[DEPTH-1].
- count  out  CNT_W  number of stages with V=1.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- State: S[0..DEPTH-1] (WIDTH bits each), V[0..DEPTH-1], count register.
- Priority per edge: reset > flush > shift_en > hold.
- reset: all S=0, all V=0, count=0. Outputs: out_data=0, out_valid=0, count=0, empty=1, full=0, tap_data=0, tap_valid=0. tap_err follows tap_sel only.
- flush (no reset): all S=0, all V=0, count=0. A simultaneous shift_en is ignored and in_data is dropped.
- shift_en=1:
  - S[0]<=in_data; V[0]<=in_valid.
  - S[i]<=S[i-1] and V[i]<=V[i-1] for i=1..DEPTH-1.
  - The old S[DEPTH-1] is discarded.
  - in_data is captured even when in_valid=0; it then sits in a bubble (V=0).
- shift_en=0: all state holds. in_valid and in_data are ignored.
- count update on shift: count <= count + in_valid - V[DEPTH-1] (old value). Incremental update; no popcount. Cannot exceed DEPTH or underflow by construction.
- full and empty are decoded combinationally from the count register.
- Latency: a word captured at shift edge k appears on out_data after shift edge k+DEPTH-1, i.e. DEPTH shifts after entry. Hold cycles add no latency in shift units.
- Tap readout:
  - Purely combinational from the registers.
  - tap_sel=0 selects the newest stage; tap_sel=DEPTH-1 equals out_data.
  - tap_sel>=DEPTH (DEPTH not a power of 2): tap_data=0, tap_valid=0, tap_err=1.
- Reset asserted mid-stream discards all contents in one cycle. The line is usable on the next edge.
- No X propagation: all stage registers are reset.

Optional Feature:
- Macro: SHIFT_DELAY_LINE_DIR_EN.
- With the macro defined:
  - Extra port dir (in, 1).
  - dir=0: forward shift, as above.
  - dir=1: reverse shift. S[DEPTH-1]<=in_data, V[DEPTH-1]<=in_valid; S[i]<=S[i+1]; the old S[0] is discarded.
  - Reverse count update: count + in_valid - V[0] (old value).
  - out_data and out_valid always reflect S[DEPTH-1] and V[DEPTH-1].
  - dir is sampled only when shift_en=1.
- Without the macro: no dir port; forward shift only.

Decomposition:
- Package shift_delay_pkg holds:
  - default WIDTH/DEPTH constants;
  - function cnt_width(depth) returning $clog2(depth+1);
  - function sel_width(depth) returning max(1,$clog2(depth)).
- Natural sub-module: shift_stage, one WIDTH-bit data register plus valid bit with load/clear inputs.
  - Instantiated DEPTH times via generate.
  - Counter, tap mux and flags stay in the top level.

Test Plan (WIDTH=16, DEPTH=8):
- Reset fill: after reset, push 0x0001..0x0008 with in_valid=1 on 8 consecutive shifts.
  - After the 8th shift: out_data=0x0001, out_valid=1, count=8, full=1, tap_sel=0 gives 0x0008.
- Bubbles and hold: alternate in_valid=1/0 with shift_en=1, insert 3 cycles of shift_en=0 mid-stream.
  - count tracks the valid words only; held cycles leave all taps unchanged.
  - out_valid pattern reproduces the input valid pattern delayed by 8 shifts.
- Steady-state throughput: at full, shift 0xAAAA with in_valid=1 → count stays 8 and out_data pops the oldest word each edge.
- Flush vs shift: at count=5, assert flush and shift_en together with in_data=0xBEEF.
  - Next cycle: count=0, empty=1, all taps 0, 0xBEEF not captured.
- Mid-operation reset: at full, assert reset for 1 cycle with shift_en=1.
  - Next cycle: all outputs 0, empty=1.
  - The following shift of 0x1234 appears at tap_sel=0 with tap_valid=1.
- Tap error (DEPTH=6 build): tap_sel=6 → tap_err=1, tap_data=0, tap_valid=0. tap_sel=5 equals out_data.
- DIR_EN build: fill forward with 1..8, then one reverse shift with in_data=0x00FF, in_valid=1.
  - Result: S[7]=0x00FF, S[0]=0x0007, the old word 0x0008 is dropped, count stays 8.

Source files
------------

// File: rtl/shift_delay_pkg.sv
// shift_delay_pkg: default geometry and derived-width helpers for shift_delay_line.
`default_nettype none

package shift_delay_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A 2-stage line still needs a 1-bit select, so clamp at 1.
  function automatic int sel_width(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// shift_stage: one data register plus valid bit; clear wins over load.
`default_nettype none

module shift_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_delay_line.sv
// shift_delay_line: parametrised delay line with per-stage valid, flush, tap readout and occupancy.
// Optional reverse shifting (dir port) is built when SHIFT_DELAY_LINE_DIR_EN is defined.
`default_nettype none

module shift_delay_line
  import shift_delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH),
  parameter int SEL_W = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef SHIFT_DELAY_LINE_DIR_EN
  input  logic             dir,
`endif
  input  logic [SEL_W-1:0] tap_sel,
  output logic [WIDTH-1:0] tap_data,
  output logic             tap_valid,
  output logic             tap_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic             drop_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_d;
    logic             fwd_v;
    logic [WIDTH-1:0] stage_d;
    logic             stage_v;

    if (i == 0) begin : g_head
      assign fwd_d = in_data;
      assign fwd_v = in_valid;
    end else begin : g_body
      assign fwd_d = s[i-1];
      assign fwd_v = v[i-1];
    end

`ifdef SHIFT_DELAY_LINE_DIR_EN
    logic [WIDTH-1:0] rev_d;
    logic             rev_v;

    if (i == DEPTH - 1) begin : g_rhead
      assign rev_d = in_data;
      assign rev_v = in_valid;
    end else begin : g_rbody
      assign rev_d = s[i+1];
      assign rev_v = v[i+1];
    end

    assign stage_d = dir ? rev_d : fwd_d;
    assign stage_v = dir ? rev_v : fwd_v;
`else
    assign stage_d = fwd_d;
    assign stage_v = fwd_v;
`endif

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (shift_en),
      .d       (stage_d),
      .d_valid (stage_v),
      .q       (s[i]),
      .q_valid (v[i])
    );
  end

  // The stage falling off the far end decides whether occupancy drops.
`ifdef SHIFT_DELAY_LINE_DIR_EN
  assign drop_valid = dir ? v[0] : v[DEPTH-1];
`else
  assign drop_valid = v[DEPTH-1];
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (shift_en) begin
      count <= count + CNT_W'(in_valid) - CNT_W'(drop_valid);
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign out_data  = s[DEPTH-1];
  assign out_valid = v[DEPTH-1];

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == SEL_W'(i)) begin
        tap_data  = s[i];
        tap_valid = v[i];
      end
    end
  end

  if ((1 << SEL_W) > DEPTH) begin : g_err_chk
    assign tap_err = (tap_sel >= SEL_W'(DEPTH));
  end else begin : g_no_err
    assign tap_err = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_delay_line.sv
// tb_shift_delay_line: directed self-checking bench; a DEPTH=6 instance shares stimulus for tap-range checks.
`default_nettype none

module tb_shift_delay_line;

  logic        clk = 1'b0;
  logic        reset, shift_en, flush, in_valid;
  logic [15:0] in_data;
  logic [2:0]  tap_sel, tap_sel6;

  logic [15:0] tap_data, out_data, tap_data6, out_data6;
  logic        tap_valid, tap_err, out_valid, full, empty;
  logic        tap_valid6, tap_err6, out_valid6, full6, empty6;
  logic [3:0]  count;
  logic [2:0]  count6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_delay_line #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .shift_en(shift_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .tap_sel(tap_sel),
    .tap_data(tap_data), .tap_valid(tap_valid), .tap_err(tap_err),
    .out_data(out_data), .out_valid(out_valid), .count(count),
    .full(full), .empty(empty)
  );

  shift_delay_line #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .tap_sel(tap_sel6),
    .tap_data(tap_data6), .tap_valid(tap_valid6), .tap_err(tap_err6),
    .out_data(out_data6), .out_valid(out_valid6), .count(count6),
    .full(full6), .empty(empty6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic vld);
    shift_en = 1'b1; in_valid = vld; in_data = d;
    step();
    shift_en = 1'b0; in_valid = 1'b0;
  endtask

  logic [7:0]  exp_v;
  logic [15:0] exp_d [8];
  logic [7:0]  pat;

  initial begin
    reset = 1'b1; shift_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = 16'h0; tap_sel = 3'd0; tap_sel6 = 3'd0;
    step(); step();
    reset = 1'b0;
    #1;

    chk("rst_out_data",  32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_empty",     32'(empty), 32'd1);
    chk("rst_full",      32'(full), 32'd0);
    chk("rst_tap_data",  32'(tap_data), 32'h0);
    chk("rst_tap_valid", 32'(tap_valid), 32'd0);
    chk("rst_tap_err",   32'(tap_err), 32'd0);

    // Fill with 1..8
    for (int k = 1; k <= 8; k++) begin
      push(16'(k), 1'b1);
      if (k == 3) chk("fill3_count", 32'(count), 32'd3);
    end
    chk("fill_out_data",  32'(out_data), 32'h0001);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    chk("fill_count",     32'(count), 32'd8);
    chk("fill_full",      32'(full), 32'd1);
    chk("fill_empty",     32'(empty), 32'd0);
    tap_sel = 3'd0; #1;
    chk("fill_tap0", 32'(tap_data), 32'h0008);
    tap_sel = 3'd3; #1;
    chk("fill_tap3", 32'(tap_data), 32'h0005);
    tap_sel = 3'd7; #1;
    chk("fill_tap7", 32'(tap_data), 32'h0001);
    tap_sel = 3'd0;

    tap_sel6 = 3'd6; #1;
    chk("d6_err6",   32'(tap_err6), 32'd1);
    chk("d6_data6",  32'(tap_data6), 32'h0);
    chk("d6_valid6", 32'(tap_valid6), 32'd0);
    tap_sel6 = 3'd7; #1;
    chk("d6_err7",   32'(tap_err6), 32'd1);
    tap_sel6 = 3'd5; #1;
    chk("d6_err5",   32'(tap_err6), 32'd0);
    chk("d6_tap5",   32'(tap_data6), 32'h0003);
    chk("d6_out",    32'(out_data6), 32'h0003);
    chk("d6_count",  32'(count6), 32'd6);
    chk("d6_full",   32'(full6), 32'd1);
    tap_sel6 = 3'd0;

    // Steady state at full
    push(16'hAAAA, 1'b1);
    chk("ss1_out",   32'(out_data), 32'h0002);
    chk("ss1_count", 32'(count), 32'd8);
    push(16'hAAAA, 1'b1);
    chk("ss2_out",   32'(out_data), 32'h0003);
    chk("ss2_count", 32'(count), 32'd8);
    chk("ss2_tap0",  32'(tap_data), 32'hAAAA);

    // Reset mid-stream with shift_en high
    reset = 1'b1; shift_en = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    step();
    reset = 1'b0; shift_en = 1'b0; in_valid = 1'b0;
    chk("mrst_out_data",  32'(out_data), 32'h0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_count",     32'(count), 32'd0);
    chk("mrst_empty",     32'(empty), 32'd1);
    chk("mrst_tap_data",  32'(tap_data), 32'h0);
    push(16'h1234, 1'b1);
    chk("mrst_tap0",       32'(tap_data), 32'h1234);
    chk("mrst_tap0_valid", 32'(tap_valid), 32'd1);
    chk("mrst_count1",     32'(count), 32'd1);

    // Bubbles with a 3-cycle hold after the third push
    for (int k = 0; k < 7; k++) begin
      push(16'h0100 + 16'(k), (k % 2) == 0);
      if (k == 2) begin
        for (int h = 0; h < 3; h++) begin
          in_valid = 1'b1; in_data = 16'hDEAD;
          step();
          in_valid = 1'b0;
          chk("hold_count", 32'(count), 32'd3);
          tap_sel = 3'd0; #1;
          chk("hold_tap0", 32'(tap_data), 32'h0102);
          tap_sel = 3'd3; #1;
          chk("hold_tap3", 32'(tap_data), 32'h1234);
          tap_sel = 3'd0;
        end
      end
    end
    chk("bub_count", 32'(count), 32'd5);
    chk("bub_out",   32'(out_data), 32'h1234);
    exp_v = 8'b1101_0101;  // bit i = expected valid of stage i
    for (int i = 0; i < 7; i++) exp_d[i] = 16'h0106 - 16'(i);
    exp_d[7] = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      tap_sel = 3'(i); #1;
      chk("bub_tap_valid", 32'(tap_valid), 32'(exp_v[i]));
      chk("bub_tap_data",  32'(tap_data), 32'(exp_d[i]));
    end
    tap_sel = 3'd0;

    // Flush beats a simultaneous shift at count=5
    flush = 1'b1; shift_en = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    flush = 1'b0; shift_en = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_out",   32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tap_sel = 3'(i); #1;
      chk("flush_tap_data",  32'(tap_data), 32'h0);
      chk("flush_tap_valid", 32'(tap_valid), 32'd0);
    end
    tap_sel = 3'd0;

    // out_valid reproduces the input valid pattern 8 shifts later
    pat = 8'b0100_1011;  // bit j = in_valid of push j
    for (int j = 0; j < 8; j++) push(16'hC000 + 16'(j), pat[j]);
    chk("pat_count", 32'(count), 32'd4);
    chk("pat_out0_valid", 32'(out_valid), 32'(pat[0]));
    chk("pat_out0_data",  32'(out_data), 32'hC000);
    for (int j = 1; j < 8; j++) begin
      push(16'h0, 1'b0);
      chk("pat_out_valid", 32'(out_valid), 32'(pat[j]));
    end
    push(16'h0, 1'b0);
    chk("pat_drain_count", 32'(count), 32'd0);
    chk("pat_drain_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
